// File: rtl/rv_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// rv_pipe_ctrl
// -----------------------------------------------------------------------------
// Hazard, stall and flush controller for the FlexRV32 pipeline. It sits between
// fetch/decode and the NUM_STAGES post-decode stages (stage 0 = first ALU
// stage, stage NUM_STAGES-1 = write) and drives every stall/flush strobe.
//
// Functions:
//   - Backpressure: a stage stalls when it, or any stage after it, is not ready.
//   - Load-use: decode is held while one of the first HAZ_STAGES stages holds a
//     load whose destination matches a source that decode actually reads.
//     Register 0 never causes a hazard.
//   - Bubbles: a stage is flushed when its upstream neighbour stalls and it
//     does not, so a stage that advances does not re-run stale contents.
//   - Redirect flush: i_pc_change flushes everything for FLUSH_CYCLES cycles.
//   - Unsupported instruction tracker: an INV_DEPTH-deep shift register of
//     "supported" bits follows accepted decode slots. When an unsupported
//     instruction reaches the head, o_inv_inst rises and the FSM parks in TRAP
//     (decode held) until the next redirect.
//
// Handshake semantics: i_stage_ready[k]=1 means stage k can hand its contents
// to stage k+1 (or retire, for the last stage) this cycle. o_stage_stall[k]=1
// means stage k must hold its contents; o_stage_flush[k]=1 means stage k must
// load a bubble at the next edge. Decode and fetch follow o_decode_stall /
// o_fetch_stall / o_decode_flush in the same way.
//
// Ports:
//   i_clk, i_reset            clock, asynchronous active-high reset
//   i_pc_change               redirect (branch/jump/trap entry)
//   i_decode_inst_sup         decoded instruction is supported
//   i_decode_rs1/_rs2         decode source indices
//   i_decode_use_rs1/_rs2     decode instruction reads rs1/rs2
//   i_stage_mem_rd[j]         stage j (j < HAZ_STAGES) holds a load
//   i_stage_rd                stage j destination at [j*REG_W +: REG_W]
//   i_stage_ready[k]          stage k can advance this cycle
//   i_need_pause              external pause request (CSR/fence)
//   o_fetch_stall             hold fetch
//   o_decode_flush            bubble decode
//   o_decode_stall            hold decode
//   o_stage_flush[k]          bubble stage k
//   o_stage_stall[k]          hold stage k
//   o_inv_inst                unsupported instruction reported / trap pending
//
// Optional feature (macro RV_PIPE_CTRL_PERF_EN):
//   o_stall_cycles            cycles with decode stalled (outside reset)
//   o_flush_events            redirects taken while in RUN
//   Both are free-running 32-bit counters that wrap.
// -----------------------------------------------------------------------------
module rv_pipe_ctrl #(
   parameter int NUM_STAGES   = 3,
   parameter int HAZ_STAGES   = 2,
   parameter int INV_DEPTH    = 2,
   parameter int FLUSH_CYCLES = 1,
   parameter int REG_W        = 5
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic                        i_pc_change,
   input  logic                        i_decode_inst_sup,
   input  logic [REG_W-1:0]            i_decode_rs1,
   input  logic [REG_W-1:0]            i_decode_rs2,
   input  logic                        i_decode_use_rs1,
   input  logic                        i_decode_use_rs2,
   input  logic [HAZ_STAGES-1:0]       i_stage_mem_rd,
   input  logic [HAZ_STAGES*REG_W-1:0] i_stage_rd,
   input  logic [NUM_STAGES-1:0]       i_stage_ready,
   input  logic                        i_need_pause,
   output logic                        o_fetch_stall,
   output logic                        o_decode_flush,
   output logic                        o_decode_stall,
   output logic [NUM_STAGES-1:0]       o_stage_flush,
   output logic [NUM_STAGES-1:0]       o_stage_stall,
`ifdef RV_PIPE_CTRL_PERF_EN
   output logic [31:0]                 o_stall_cycles,
   output logic [31:0]                 o_flush_events,
`endif
   output logic                        o_inv_inst
);

   // ---------------------------------------------------------------------------
   // Types and constants
   // ---------------------------------------------------------------------------
   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_TRAP  = 2'd2
   } state_t;

   // FLUSH_CYCLES is at most 4, so the remaining-cycle counter needs 2 bits.
   localparam int         CNT_W      = 2;
   localparam logic [1:0] CNT_RST    = CNT_W'(FLUSH_CYCLES - 1);
   // The redirect cycle itself is already a flush cycle, hence the -2 reload.
   localparam logic [1:0] CNT_RELOAD = (FLUSH_CYCLES > 1) ? CNT_W'(FLUSH_CYCLES - 2) : '0;
   localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [INV_DEPTH-1:0]  tracker_q, tracker_d;

   // ---------------------------------------------------------------------------
   // Combinational intermediates
   // ---------------------------------------------------------------------------
   logic [NUM_STAGES-1:0] stall_v;
   logic                  stall_acc;
   logic                  haz;
   logic [REG_W-1:0]      rd_j;
   logic                  decode_stall;
   logic                  global_flush;
   logic                  head_sup;
   logic [NUM_STAGES-1:0] stage_flush_v;

   assign head_sup = tracker_q[INV_DEPTH-1];

   // Stall chain: walking from the write stage back towards stage 0, a stage
   // stalls as soon as any stage at or after it is not ready.
   always_comb begin
      stall_v   = '0;
      stall_acc = 1'b0;
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
         stall_acc  = stall_acc | ~i_stage_ready[k];
         stall_v[k] = stall_acc;
      end
   end

   // Load-use hazard: only sources the instruction really reads count, and a
   // load to x0 produces nothing to wait for.
   always_comb begin
      haz  = 1'b0;
      rd_j = '0;
      for (int j = 0; j < HAZ_STAGES; j++) begin
         rd_j = i_stage_rd[j*REG_W +: REG_W];
         if (i_stage_mem_rd[j] && (rd_j != '0) &&
             ((i_decode_use_rs1 && (i_decode_rs1 == rd_j)) ||
              (i_decode_use_rs2 && (i_decode_rs2 == rd_j)))) begin
            haz = 1'b1;
         end
      end
   end

   assign decode_stall = haz | i_need_pause | stall_v[0] | (state_q == ST_TRAP);
   assign global_flush = i_reset | i_pc_change | (state_q == ST_FLUSH);

   // Bubble insertion. Decode acts as stage -1 for stage 0, so a decode-only
   // stall (hazard/pause/trap) bubbles stage 0, but not when stage 0 is itself
   // held by downstream backpressure.
   always_comb begin
      stage_flush_v    = '0;
      stage_flush_v[0] = global_flush | (decode_stall & ~stall_v[0]);
      for (int k = 1; k < NUM_STAGES; k++) begin
         stage_flush_v[k] = global_flush | (stall_v[k-1] & ~stall_v[k]);
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs. Stalls are masked while reset is held so the pipeline only sees
   // flushes during reset, whatever the ready inputs are doing.
   // ---------------------------------------------------------------------------
   assign o_decode_stall = decode_stall & ~i_reset;
   assign o_fetch_stall  = decode_stall & ~i_reset;
   assign o_decode_flush = global_flush;
   assign o_stage_flush  = stage_flush_v;
   assign o_stage_stall  = i_reset ? '0 : stall_v;
   assign o_inv_inst     = ~i_reset &
                           (((state_q == ST_RUN) & ~head_sup) | (state_q == ST_TRAP));

   // ---------------------------------------------------------------------------
   // FSM next state. A redirect always outranks trap entry.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_RUN: begin
            if (i_pc_change) begin
               if (MULTI_FLUSH) begin
                  state_d = ST_FLUSH;
                  cnt_d   = CNT_RELOAD;
               end
            end else if (!head_sup) begin
               state_d = ST_TRAP;
            end
         end
         ST_FLUSH: begin
            if (i_pc_change) begin
               if (MULTI_FLUSH) begin
                  cnt_d = CNT_RELOAD;
               end else begin
                  state_d = ST_RUN;
               end
            end else if (cnt_q == '0) begin
               state_d = ST_RUN;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_TRAP: begin
            if (i_pc_change) begin
               if (MULTI_FLUSH) begin
                  state_d = ST_FLUSH;
                  cnt_d   = CNT_RELOAD;
               end else begin
                  state_d = ST_RUN;
               end
            end
         end
         default: begin
            state_d = ST_FLUSH;
            cnt_d   = CNT_RST;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Unsupported-instruction tracker. It only advances on accepted decode slots
   // and is refilled with "supported" on every flush, so squashed instructions
   // can never raise o_inv_inst.
   // ---------------------------------------------------------------------------
   always_comb begin
      tracker_d = tracker_q;
      if (global_flush) begin
         tracker_d = '1;
      end else if (!decode_stall) begin
         tracker_d[0] = i_decode_inst_sup;
         for (int i = 1; i < INV_DEPTH; i++) begin
            tracker_d[i] = tracker_q[i-1];
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q   <= ST_FLUSH;
         cnt_q     <= CNT_RST;
         tracker_q <= '1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tracker_q <= tracker_d;
      end
   end

`ifdef RV_PIPE_CTRL_PERF_EN
   // ---------------------------------------------------------------------------
   // Performance counters
   // ---------------------------------------------------------------------------
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q + {31'd0, decode_stall};
      flush_cnt_d = flush_cnt_q + {31'd0, (i_pc_change & (state_q == ST_RUN))};
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign o_stall_cycles = stall_cnt_q;
   assign o_flush_events = flush_cnt_q;
`endif

endmodule

// File: tb/tb_rv_pipe_ctrl.sv
// Bench for rv_pipe_ctrl. Two instances share the stimulus: dut_a uses the
// default parameters (FLUSH_CYCLES=1), dut_b uses FLUSH_CYCLES=3.
// Observed vector layout: {fetch_stall, decode_stall, decode_flush,
// stage_flush[2:0], stage_stall[2:0], inv_inst}.
module tb_rv_pipe_ctrl;

   localparam int NS = 3;
   localparam int HS = 2;
   localparam int RW = 5;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic             pc;
   logic             sup;
   logic [RW-1:0]    rs1, rs2;
   logic             use1, use2;
   logic [HS-1:0]    mem_rd;
   logic [HS*RW-1:0] st_rd;
   logic [NS-1:0]    ready;
   logic             pause;

   logic          fs_a, df_a, ds_a, inv_a;
   logic [NS-1:0] sf_a, ss_a;
   logic          fs_b, df_b, ds_b, inv_b;
   logic [NS-1:0] sf_b, ss_b;
`ifdef RV_PIPE_CTRL_PERF_EN
   logic [31:0]   sc_a, fe_a, sc_b, fe_b;
`endif

   logic [9:0] obs_a, obs_b;
   assign obs_a = {fs_a, ds_a, df_a, sf_a, ss_a, inv_a};
   assign obs_b = {fs_b, ds_b, df_b, sf_b, ss_b, inv_b};

   logic [9:0] exp_q[$];
   logic [9:0] exp3_q[$];
   int checks = 0;
   int errors = 0;

   rv_pipe_ctrl dut_a (
      .i_clk(clk), .i_reset(rst), .i_pc_change(pc), .i_decode_inst_sup(sup),
      .i_decode_rs1(rs1), .i_decode_rs2(rs2),
      .i_decode_use_rs1(use1), .i_decode_use_rs2(use2),
      .i_stage_mem_rd(mem_rd), .i_stage_rd(st_rd), .i_stage_ready(ready),
      .i_need_pause(pause),
      .o_fetch_stall(fs_a), .o_decode_flush(df_a), .o_decode_stall(ds_a),
      .o_stage_flush(sf_a), .o_stage_stall(ss_a),
`ifdef RV_PIPE_CTRL_PERF_EN
      .o_stall_cycles(sc_a), .o_flush_events(fe_a),
`endif
      .o_inv_inst(inv_a)
   );

   rv_pipe_ctrl #(.FLUSH_CYCLES(3)) dut_b (
      .i_clk(clk), .i_reset(rst), .i_pc_change(pc), .i_decode_inst_sup(sup),
      .i_decode_rs1(rs1), .i_decode_rs2(rs2),
      .i_decode_use_rs1(use1), .i_decode_use_rs2(use2),
      .i_stage_mem_rd(mem_rd), .i_stage_rd(st_rd), .i_stage_ready(ready),
      .i_need_pause(pause),
      .o_fetch_stall(fs_b), .o_decode_flush(df_b), .o_decode_stall(ds_b),
      .o_stage_flush(sf_b), .o_stage_stall(ss_b),
`ifdef RV_PIPE_CTRL_PERF_EN
      .o_stall_cycles(sc_b), .o_flush_events(fe_b),
`endif
      .o_inv_inst(inv_b)
   );

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   function automatic logic [9:0] mk(logic ds, logic df, logic [2:0] sf, logic [2:0] ss, logic inv);
      return {ds, ds, df, sf, ss, inv};
   endfunction

   task automatic set_idle();
      rst = 1'b0; pc = 1'b0; sup = 1'b1; rs1 = '0; rs2 = '0;
      use1 = 1'b0; use2 = 1'b0; mem_rd = '0; st_rd = '0; ready = '1; pause = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Load-use stimulus: stage 1 holds a load to x5, decode reads x5 via rs2.
   task automatic drive_hazard();
      mem_rd = 2'b10; st_rd = {5'd5, 5'd0}; rs2 = 5'd5; use2 = 1'b1;
   endtask

   // Reset, then idle until both instances are back in RUN.
   task automatic do_reset();
      set_idle();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      tick(); tick(); tick();
   endtask

   // ---------------------------------------------------------------------------
   // Tests
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      logic [9:0] e;
      do_reset();
      // Steer dut_a into TRAP: one unsupported slot, two supported ones.
      for (int i = 0; i < 4; i++) begin
         set_idle();
         case (i)
            0: begin sup = 1'b0; e = mk(0, 0, 3'b000, 3'b000, 0); end
            1: e = mk(0, 0, 3'b000, 3'b000, 0);
            2: e = mk(0, 0, 3'b000, 3'b000, 1);
            default: e = mk(1, 0, 3'b001, 3'b000, 1);
         endcase
         exp_q.push_back(e);
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (obs_a !== e) begin
            errors++;
            $display("FAIL reset_pre step %0d: got %b expected %b", i, obs_a, e);
         end
         tick();
      end
      // Reset mid-TRAP with every stage not ready, then release.
      for (int i = 0; i < 3; i++) begin
         set_idle();
         case (i)
            0: begin rst = 1'b1; ready = 3'b000; e = mk(0, 1, 3'b111, 3'b000, 0); end
            1: e = mk(0, 1, 3'b111, 3'b000, 0);
            default: e = mk(0, 0, 3'b000, 3'b000, 0);
         endcase
         exp_q.push_back(e);
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (obs_a !== e) begin
            errors++;
            $display("FAIL reset step %0d: got %b expected %b", i, obs_a, e);
         end
         tick();
      end
   endtask

   task automatic test_load_use();
      logic [9:0] e;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         set_idle();
         case (i)
            0: begin drive_hazard(); e = mk(1, 0, 3'b001, 3'b000, 0); end
            1: begin drive_hazard(); use2 = 1'b0; e = mk(0, 0, 3'b000, 3'b000, 0); end
            2: begin drive_hazard(); st_rd = '0; rs2 = '0; e = mk(0, 0, 3'b000, 3'b000, 0); end
            3: begin mem_rd = 2'b01; st_rd = {5'd0, 5'd7}; rs1 = 5'd7; use1 = 1'b1;
                     e = mk(1, 0, 3'b001, 3'b000, 0); end
            4: begin drive_hazard(); mem_rd = 2'b00; e = mk(0, 0, 3'b000, 3'b000, 0); end
            5: begin drive_hazard(); ready = 3'b110; e = mk(1, 0, 3'b010, 3'b001, 0); end
            6: begin ready = 3'b110; e = mk(1, 0, 3'b010, 3'b001, 0); end
            default: begin mem_rd = 2'b10; st_rd = {5'd9, 5'd0}; rs1 = 5'd9;
                           rs2 = 5'd3; use2 = 1'b1; e = mk(0, 0, 3'b000, 3'b000, 0); end
         endcase
         exp_q.push_back(e);
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (obs_a !== e) begin
            errors++;
            $display("FAIL load_use case %0d: got %b expected %b", i, obs_a, e);
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      logic [9:0] e;
      logic [2:0] st, sf;
      logic       h, ds;
      do_reset();
      set_idle();
      ready = 3'b101;
      exp_q.push_back(mk(1, 0, 3'b100, 3'b011, 0));
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs_a !== e) begin
         errors++;
         $display("FAIL backpressure_101: got %b expected %b", obs_a, e);
      end
      tick();
      for (int i = 0; i < 20; i++) begin
         set_idle();
         ready = 3'($urandom_range(0, 7));
         h     = 1'($urandom_range(0, 1));
         pause = ($urandom_range(0, 3) == 0);
         if (h) drive_hazard();
         for (int k = 0; k < 3; k++) begin
            st[k] = 1'b0;
            for (int j = k; j < 3; j++) if (!ready[j]) st[k] = 1'b1;
         end
         ds    = h | pause | st[0];
         sf[0] = ds & ~st[0];
         sf[1] = st[0] & ~st[1];
         sf[2] = st[1] & ~st[2];
         exp_q.push_back(mk(ds, 0, sf, st, 0));
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (obs_a !== e) begin
            errors++;
            $display("FAIL backpressure_rand ready=%b haz=%b: got %b expected %b",
                     ready, h, obs_a, e);
         end
         tick();
      end
   endtask

   task automatic test_redirect();
      logic [9:0] e, f, z;
      f = mk(0, 1, 3'b111, 3'b000, 0);
      z = mk(0, 0, 3'b000, 3'b000, 0);
      do_reset();
      // Single pulse: dut_b flushes cycles 0..2, dut_a only cycle 0.
      for (int i = 0; i < 4; i++) begin
         set_idle();
         pc = (i == 0);
         exp_q.push_back((i == 0) ? f : z);
         exp3_q.push_back((i < 3) ? f : z);
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (obs_a !== e) begin
            errors++;
            $display("FAIL redirect1_a cycle %0d: got %b expected %b", i, obs_a, e);
         end
         e = exp3_q.pop_front();
         checks++;
         if (obs_b !== e) begin
            errors++;
            $display("FAIL redirect1_b cycle %0d: got %b expected %b", i, obs_b, e);
         end
         tick();
      end
      // Second redirect in cycle 2 stretches dut_b's flush through cycle 4.
      for (int i = 0; i < 6; i++) begin
         set_idle();
         pc = (i == 0) || (i == 2);
         exp_q.push_back(pc ? f : z);
         exp3_q.push_back((i < 5) ? f : z);
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (obs_a !== e) begin
            errors++;
            $display("FAIL redirect2_a cycle %0d: got %b expected %b", i, obs_a, e);
         end
         e = exp3_q.pop_front();
         checks++;
         if (obs_b !== e) begin
            errors++;
            $display("FAIL redirect2_b cycle %0d: got %b expected %b", i, obs_b, e);
         end
         tick();
      end
   endtask

   task automatic test_trap();
      logic [9:0] e, z;
      z = mk(0, 0, 3'b000, 3'b000, 0);
      do_reset();
      // Unsupported slot, one more slot, report, 5 paused TRAP cycles,
      // redirect, back to RUN.
      for (int i = 0; i < 10; i++) begin
         set_idle();
         case (i)
            0: begin sup = 1'b0; e = z; end
            1: e = z;
            2: e = mk(0, 0, 3'b000, 3'b000, 1);
            3, 4, 5, 6, 7: begin pause = 1'b1; e = mk(1, 0, 3'b001, 3'b000, 1); end
            8: begin pc = 1'b1; e = mk(1, 1, 3'b111, 3'b000, 1); end
            default: e = z;
         endcase
         exp_q.push_back(e);
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (obs_a !== e) begin
            errors++;
            $display("FAIL trap step %0d: got %b expected %b", i, obs_a, e);
         end
         tick();
      end
      // Redirect in the same cycle the head turns invalid: no TRAP.
      do_reset();
      for (int i = 0; i < 6; i++) begin
         set_idle();
         case (i)
            0: sup = 1'b0;
            2: pc = 1'b1;
            default: ;
         endcase
         exp_q.push_back((i == 2) ? mk(0, 1, 3'b111, 3'b000, 1) : z);
         exp3_q.push_back((i == 2) ? mk(0, 1, 3'b111, 3'b000, 1) :
                          (i == 3 || i == 4) ? mk(0, 1, 3'b111, 3'b000, 0) : z);
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if (obs_a !== e) begin
            errors++;
            $display("FAIL trap_vs_redirect_a step %0d: got %b expected %b", i, obs_a, e);
         end
         e = exp3_q.pop_front();
         checks++;
         if (obs_b !== e) begin
            errors++;
            $display("FAIL trap_vs_redirect_b step %0d: got %b expected %b", i, obs_b, e);
         end
         tick();
      end
   endtask

`ifdef RV_PIPE_CTRL_PERF_EN
   task automatic test_perf();
      do_reset();
      @(negedge clk);
      checks++;
      if (sc_a !== 32'd0 || fe_a !== 32'd0) begin
         errors++;
         $display("FAIL perf_reset: got %0d/%0d expected 0/0", sc_a, fe_a);
      end
      tick();
      for (int i = 0; i < 4; i++) begin
         set_idle(); drive_hazard(); tick();
      end
      for (int r = 0; r < 2; r++) begin
         set_idle(); pc = 1'b1; tick();
         set_idle(); tick(); tick(); tick();
      end
      @(negedge clk);
      checks++;
      if (sc_a !== 32'd4) begin
         errors++;
         $display("FAIL perf_stall_a: got %0d expected 4", sc_a);
      end
      checks++;
      if (fe_a !== 32'd2) begin
         errors++;
         $display("FAIL perf_flush_a: got %0d expected 2", fe_a);
      end
      checks++;
      if (sc_b !== 32'd4 || fe_b !== 32'd2) begin
         errors++;
         $display("FAIL perf_b: got %0d/%0d expected 4/2", sc_b, fe_b);
      end
      tick();
   endtask
`endif

   // ---------------------------------------------------------------------------
   // Sequencer and final report
   // ---------------------------------------------------------------------------
   initial begin
      set_idle();
      rst = 1'b1;
      test_reset();
      test_load_use();
      test_backpressure();
      test_redirect();
      test_trap();
`ifdef RV_PIPE_CTRL_PERF_EN
      test_perf();
`endif
      if (exp_q.size() != 0 || exp3_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d/%0d entries left, expected 0",
                  exp_q.size(), exp3_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached after %0d checks", checks);
      $fatal(1, "watchdog");
   end

endmodule
